// File: rtl/break_watch_unit_if.sv
// break_watch_unit_if
//   Bundles the CPU-side observation signals, the configuration port and the
//   halt/hit reporting outputs of break_watch_unit.
//   Ports (via modports):
//     slave  : the break/watch unit (inputs observed, outputs reported)
//     master : CPU / debugger side driving the observation and config inputs
//   Signals:
//     iRetire, iPC                       retiring instruction
//     iDReadEnable, iDWriteEnable,
//     iDAddress                          data-bus strobes and address
//     iCfgWe, iCfgIdx, iCfgMode,
//     iCfgAddr, iCfgMask, iCfgThresh     channel configuration write
//     iResume, iStepReq                  debugger control
//     oBreak, oHitValid, oHitIdx,
//     oHitMask, oHitAddr, oState         halt request and hit report
interface break_watch_unit_if #(
    parameter int NUM_CH = 4,
    parameter int PC_W   = 32,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 8,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              iRetire;
    logic [PC_W-1:0]   iPC;
    logic              iDReadEnable;
    logic              iDWriteEnable;
    logic [ADDR_W-1:0] iDAddress;
    logic              iCfgWe;
    logic [IDX_W-1:0]  iCfgIdx;
    logic [1:0]        iCfgMode;
    logic [ADDR_W-1:0] iCfgAddr;
    logic [ADDR_W-1:0] iCfgMask;
    logic [CNT_W-1:0]  iCfgThresh;
    logic              iResume;
    logic              iStepReq;
    logic              oBreak;
    logic              oHitValid;
    logic [IDX_W-1:0]  oHitIdx;
    logic [NUM_CH-1:0] oHitMask;
    logic [ADDR_W-1:0] oHitAddr;
    logic [1:0]        oState;

    modport master (
        output iRetire, iPC, iDReadEnable, iDWriteEnable, iDAddress,
               iCfgWe, iCfgIdx, iCfgMode, iCfgAddr, iCfgMask, iCfgThresh,
               iResume, iStepReq,
        input  oBreak, oHitValid, oHitIdx, oHitMask, oHitAddr, oState
    );

    modport slave (
        input  iRetire, iPC, iDReadEnable, iDWriteEnable, iDAddress,
               iCfgWe, iCfgIdx, iCfgMode, iCfgAddr, iCfgMask, iCfgThresh,
               iResume, iStepReq,
        output oBreak, oHitValid, oHitIdx, oHitMask, oHitAddr, oState
    );
endinterface

// File: rtl/break_watch_unit.sv
// break_watch_unit
//   Breakpoint/watchpoint unit for the LEGv8 CPU. NUM_CH independent channels
//   compare the retiring PC (exec mode) or the data-bus address (write or
//   read/write mode) against a masked address, count hits up to a threshold
//   and, on firing, halt the CPU through a registered break request.
//   Ports:
//     iCLK  : CPU clock
//     iRST  : asynchronous active-high reset
//     bus   : break_watch_unit_if.slave (observation, config, control, report)
//   Modules in this file:
//     break_watch_chan : one channel (config registers, matcher, hit counter)
//     break_watch_unit : channel array, priority encoder, RUN/HALT/STEP FSM

module break_watch_chan #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [ADDR_W-1:0] cfg_mask,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              retire,
    input  logic [ADDR_W-1:0] pc_ext,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              qual_en,   // RUN and not suppressed
    output logic              fire,
    output logic              is_exec
);
    localparam logic [1:0] M_EXEC = 2'b01;
    localparam logic [1:0] M_WR   = 2'b10;
    localparam logic [1:0] M_RW   = 2'b11;

    logic [1:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] mask;
    logic [CNT_W-1:0]  thresh;
    logic [CNT_W-1:0]  hits;

    logic              pc_eq;
    logic              d_eq;
    logic              match;
    logic              counted;
    logic [CNT_W:0]    hits_inc;
    logic [CNT_W:0]    thr_eff;

    assign pc_eq = ((pc_ext ^ addr) & ~mask) == '0;
    assign d_eq  = ((d_addr ^ addr) & ~mask) == '0;

    always_comb begin
        match = 1'b0;
        case (mode)
            M_EXEC:  match = retire & pc_eq;
            M_WR:    match = wr_en & d_eq;
            M_RW:    match = (rd_en | wr_en) & d_eq;
            default: match = 1'b0;
        endcase
    end

    // A config write on this channel overrides a coincident match.
    assign counted  = match & qual_en & ~cfg_we;
    // One extra bit so the saturated count plus one still compares correctly.
    assign hits_inc = {1'b0, hits} + 1'b1;
    assign thr_eff  = (thresh == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, thresh};
    assign fire     = counted & (hits_inc >= thr_eff);
    assign is_exec  = (mode == M_EXEC);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mode   <= 2'b00;
            addr   <= '0;
            mask   <= '0;
            thresh <= '0;
            hits   <= '0;
        end else if (cfg_we) begin
            mode   <= cfg_mode;
            addr   <= cfg_addr;
            mask   <= cfg_mask;
            thresh <= cfg_thresh;
            hits   <= '0;
        end else if (fire) begin
            hits   <= '0;
        end else if (counted && !(&hits)) begin
            hits   <= hits + 1'b1;
        end
    end
endmodule

module break_watch_unit #(
    parameter int NUM_CH = 4,
    parameter int PC_W   = 32,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    break_watch_unit_if.slave     bus
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic              supp, supp_nxt;

    logic [ADDR_W-1:0] pc_ext;
    logic              qual_en;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] is_exec;
    logic              any_fire;
    logic [IDX_W-1:0]  first_idx;
    logic              first_exec;

    logic              brk_q;
    logic              hit_valid_q;
    logic [IDX_W-1:0]  hit_idx_q;
    logic [NUM_CH-1:0] hit_mask_q;
    logic [ADDR_W-1:0] hit_addr_q;

    assign pc_ext  = ADDR_W'(bus.iPC);
    assign qual_en = (state == ST_RUN) & ~supp;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        break_watch_chan #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .iCLK       (iCLK),
            .iRST       (iRST),
            .cfg_we     (bus.iCfgWe && (bus.iCfgIdx == IDX_W'(c))),
            .cfg_mode   (bus.iCfgMode),
            .cfg_addr   (bus.iCfgAddr),
            .cfg_mask   (bus.iCfgMask),
            .cfg_thresh (bus.iCfgThresh),
            .retire     (bus.iRetire),
            .pc_ext     (pc_ext),
            .rd_en      (bus.iDReadEnable),
            .wr_en      (bus.iDWriteEnable),
            .d_addr     (bus.iDAddress),
            .qual_en    (qual_en),
            .fire       (fire[c]),
            .is_exec    (is_exec[c])
        );
    end

    assign any_fire = |fire;

    // Lowest firing index wins: scan downward so the last assignment is the lowest.
    always_comb begin
        first_idx  = '0;
        first_exec = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (fire[c]) begin
                first_idx  = IDX_W'(c);
                first_exec = is_exec[c];
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= ST_RUN;
            supp  <= 1'b0;
        end else begin
            state <= state_nxt;
            supp  <= supp_nxt;
        end
    end

    // Suppress is only ever set on resume, so it is live only in RUN; the
    // retire that clears it is itself not counted (it is the instruction that
    // sat at the breakpoint when we halted).
    always_comb begin
        state_nxt = state;
        supp_nxt  = supp;
        case (state)
            ST_RUN: begin
                if (any_fire)
                    state_nxt = ST_HALT;
                if (supp && bus.iRetire)
                    supp_nxt = 1'b0;
            end
            ST_HALT: begin
                if (bus.iStepReq) begin
                    state_nxt = ST_STEP;
                end else if (bus.iResume) begin
                    state_nxt = ST_RUN;
                    supp_nxt  = 1'b1;
                end
            end
            ST_STEP: begin
                if (bus.iRetire)
                    state_nxt = ST_HALT;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Hit report: loaded only when a new halt is entered. A step halt reports
    // the stepped PC with no channel attribution (mask and index cleared).
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            brk_q       <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
            hit_mask_q  <= '0;
            hit_addr_q  <= '0;
        end else begin
            brk_q <= (state_nxt == ST_HALT);
            if (state == ST_RUN && any_fire) begin
                hit_valid_q <= 1'b1;
                hit_idx_q   <= first_idx;
                hit_mask_q  <= fire;
                hit_addr_q  <= first_exec ? pc_ext : bus.iDAddress;
            end else if (state == ST_STEP && bus.iRetire) begin
                hit_valid_q <= 1'b0;
                hit_idx_q   <= '0;
                hit_mask_q  <= '0;
                hit_addr_q  <= pc_ext;
            end
        end
    end

    assign bus.oBreak    = brk_q;
    assign bus.oHitValid = hit_valid_q;
    assign bus.oHitIdx   = hit_idx_q;
    assign bus.oHitMask  = hit_mask_q;
    assign bus.oHitAddr  = hit_addr_q;
    assign bus.oState    = state;
endmodule
